// File: rtl/core_sequencer.sv
// core_sequencer: per-core control FSM that walks every instruction through
// FETCH..UPDATE, broadcasts core_state to the block datapath, owns the shared
// PC, stalls on outstanding thread memory ops and retires on RET.
// Sticky flags report SIMD divergence and long memory waits.
module core_sequencer #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int WAIT_TIMEOUT      = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [THREADS_PER_BLOCK-1:0]         thread_enable,
    input  logic                                 fetcher_done,
    input  logic                                 decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic                                 done,
    output logic [15:0]                          instr_retired,
    output logic                                 diverge_err,
    output logic                                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] LSU_REQUESTING = 2'd1;
    localparam logic [1:0] LSU_WAITING    = 2'd2;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic                 done_q, done_d;
    logic [15:0]          retired_q, retired_d;
    logic                 diverge_q, diverge_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          wait_cnt_q, wait_cnt_d;

    logic                 busy;
    logic                 lead_found;
    logic                 pc_mismatch;
    logic [PC_BITS-1:0]   lead_pc;
    logic [15:0]          wait_inc;
    logic [15:0]          retired_inc;

    // Summarise the enabled lanes: memory busy, lowest-index next PC, and disagreement.
    always_comb begin
        busy        = 1'b0;
        lead_found  = 1'b0;
        pc_mismatch = 1'b0;
        lead_pc     = '0;
        for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
            if (thread_enable[t]) begin
                if ((lsu_state[2*t +: 2] == LSU_REQUESTING) ||
                    (lsu_state[2*t +: 2] == LSU_WAITING)) begin
                    busy = 1'b1;
                end
                if (!lead_found) begin
                    lead_pc    = next_pc[PC_BITS*t +: PC_BITS];
                    lead_found = 1'b1;
                end else if (next_pc[PC_BITS*t +: PC_BITS] != lead_pc) begin
                    pc_mismatch = 1'b1;
                end
            end
        end
    end

    assign wait_inc    = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    assign retired_inc = (retired_q  == 16'hFFFF) ? retired_q  : retired_q  + 16'd1;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: fixed single-cycle stages, FETCH and WAIT are the only holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (|thread_enable) ? S_FETCH : S_DONE;
            S_FETCH:   if (fetcher_done) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if (!busy) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE:  state_d = decoded_ret ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: PC, retire count, wait counter and sticky flags.
    always_comb begin
        pc_d       = pc_q;
        done_d     = done_q;
        retired_d  = retired_q;
        diverge_d  = diverge_q;
        timeout_d  = timeout_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d       = '0;
                    retired_d  = '0;
                    diverge_d  = 1'b0;
                    timeout_d  = 1'b0;
                    wait_cnt_d = '0;
                    // An empty mask has nothing to run, so the block is finished at once.
                    done_d     = ~(|thread_enable);
                end
            end
            S_WAIT: begin
                if (busy) begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= 16'(WAIT_TIMEOUT)) timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_UPDATE: begin
                retired_d = retired_inc;
                if (decoded_ret) begin
                    done_d = 1'b1;
                end else begin
                    // Lowest enabled lane steers the shared PC even when lanes disagree.
                    pc_d = lead_pc;
                    if (pc_mismatch) diverge_d = 1'b1;
                end
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            done_q     <= 1'b0;
            retired_q  <= '0;
            diverge_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            done_q     <= done_d;
            retired_q  <= retired_d;
            diverge_q  <= diverge_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign core_state    = state_q;
    assign current_pc    = pc_q;
    assign done          = done_q;
    assign instr_retired = retired_q;
    assign diverge_err   = diverge_q;
    assign timeout_err   = timeout_q;

endmodule
